// File: rtl/matrix_result_reader.sv
// matrix_result_reader
//
// Reads a finished N x N result matrix out of the C result BRAM and
// presents it as a valid/ready word stream in row-major order. Element
// idx sits at BRAM word address (base_addr + idx) mod 2^ADDR_W, which is
// row idx/N, column idx%N.
//
// Reads are issued against a credit limit: words already buffered plus
// reads still in flight never exceed FIFO_DEPTH. Every issued word
// therefore has a FIFO slot waiting for it, and backpressure can never
// drop or duplicate data. With the consumer always ready the block moves
// one word per cycle.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start         begin a readout (only looked at while idle)
//   base_addr     word address of C[0][0], latched on an accepted start
//   busy          high from the accepted start through the done cycle
//   done          one-cycle pulse on the handshake of the final word
//   bram_en       C BRAM read enable
//   bram_addr     C BRAM read address
//   bram_rdata    C BRAM read data, valid READ_LAT cycles after bram_en
//   m_valid       stream word valid
//   m_ready       stream consumer ready
//   m_data        stream word
//   m_last        marks element N*N-1
module matrix_result_reader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int N          = 128,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_reg;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  out_idx;
    logic [READ_LAT-1:0] rd_pipe;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              last_accept;

    // Reads still travelling through the BRAM are the set bits of the
    // latency pipe; counting them keeps the credit check exact.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + CNT_W'(rd_pipe[i]);
        end
    end

    // A read is only issued when its returning word is guaranteed a FIFO
    // slot, counting both buffered words and reads still in the BRAM.
    always_comb begin
        credit_used = {1'b0, fifo_count} + {1'b0, inflight};
        issue       = (state == READ) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
        fifo_wr     = rd_pipe[READ_LAT-1];
        fifo_rd     = m_valid && m_ready;
        last_accept = fifo_rd && (out_idx == LAST_IDX);
    end

    // Outputs are combinational views of the state so the first read goes
    // out in the cycle right after start is accepted. The address is
    // forced to zero whenever no read is being issued.
    always_comb begin
        bram_en   = issue;
        bram_addr = issue ? (base_reg + idx[ADDR_W-1:0]) : '0;
        busy      = (state != IDLE);
        done      = last_accept && (state == DRAIN);
        m_valid   = (fifo_count != '0);
        m_data    = fifo_mem[rd_ptr];
        m_last    = m_valid && (out_idx == LAST_IDX);
    end

    // Sequencer: latch the base on start, step the issue index while
    // credits allow, then wait in DRAIN for the final word to be taken.
    // A start seen outside IDLE is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            base_reg <= '0;
            idx      <= '0;
            out_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_reg <= base_addr;
                        idx      <= '0;
                        out_idx  <= '0;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        idx <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE && fifo_rd) begin
                out_idx <= out_idx + 1'b1;
            end
        end
    end

    // Latency pipe mirrors bram_en; the bit leaving the far end marks the
    // cycle in which bram_rdata belongs to us. Clearing it on reset is
    // what discards data from reads that were aborted by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= (rd_pipe << 1) | READ_LAT'(issue);
        end
    end

    // Output buffer. A write and a pop in the same cycle leave the count
    // unchanged; the credit check above means a write never finds it full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                fifo_mem[wr_ptr] <= bram_rdata;
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (fifo_rd) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
